// File: rtl/cla_adder.sv
// 4-bit carry-lookahead slice: flattened two-level carries, group G/P export,
// signed overflow flag, plus a one-cycle registered copy of the result.
module cla_adder #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] X,
  input  logic [WIDTH-1:0] Y,
  input  logic             c0,
  output logic [WIDTH-1:0] S,
  output logic             cout,
  output logic             G,
  output logic             P,
  output logic             ovf,
  output logic [WIDTH-1:0] S_r,
  output logic             cout_r,
  output logic             ovf_r
);

  logic [WIDTH-1:0] g;
  logic [WIDTH-1:0] p;
  logic [WIDTH-1:0] c;

  logic [WIDTH-1:0] s_reg    = '0;
  logic             cout_reg = 1'b0;
  logic             ovf_reg  = 1'b0;

  genvar gi;
  generate
    for (gi = 0; gi < WIDTH; gi++) begin : g_bit
      assign g[gi] = X[gi] & Y[gi];
      assign p[gi] = X[gi] ^ Y[gi];
      assign S[gi] = p[gi] ^ c[gi];
    end
  endgenerate

  // Every carry is a flat sum of products of g/p/c0; no carry feeds another.
  assign c[0] = c0;
  assign c[1] = g[0] | (p[0] & c0);
  assign c[2] = g[1] | (p[1] & g[0]) | (p[1] & p[0] & c0);
  assign c[3] = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0])
              | (p[2] & p[1] & p[0] & c0);
  assign cout = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1])
              | (p[3] & p[2] & p[1] & g[0]) | (p[3] & p[2] & p[1] & p[0] & c0);

  assign G   = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1])
             | (p[3] & p[2] & p[1] & g[0]);
  assign P   = p[3] & p[2] & p[1] & p[0];
  assign ovf = c[3] ^ cout;

  always_ff @(posedge clk) begin
    if (reset) begin
      s_reg    <= '0;
      cout_reg <= 1'b0;
      ovf_reg  <= 1'b0;
    end else begin
      s_reg    <= S;
      cout_reg <= cout;
      ovf_reg  <= ovf;
    end
  end

  assign S_r    = s_reg;
  assign cout_r = cout_reg;
  assign ovf_r  = ovf_reg;

endmodule

// File: tb/tb_cla_adder.sv
// Self-checking bench for cla_adder: exhaustive combinational sweep, corners,
// registered-path scoreboard, reset behaviour and a four-slice ripple chain.
module tb_cla_adder;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic [3:0] X = '0, Y = '0;
  logic       c0 = 1'b0;
  logic [3:0] S, S_r;
  logic       cout, G, P, ovf, cout_r, ovf_r;

  int n_vec  = 0;
  int n_fail = 0;

  // expected {ovf, cout, S} for the registered outputs
  logic [5:0] sb_q[$];

  cla_adder #(.WIDTH(4)) dut (
    .clk(clk), .reset(reset), .X(X), .Y(Y), .c0(c0),
    .S(S), .cout(cout), .G(G), .P(P), .ovf(ovf),
    .S_r(S_r), .cout_r(cout_r), .ovf_r(ovf_r)
  );

  // four slices rippled as in a 16-bit word adder
  logic [15:0] cx = '0, cy = '0, csum, csum_r;
  logic [4:0]  cc;
  logic [3:0]  cg, cp, covf, ccout_r, covf_r;
  assign cc[0] = 1'b0;

  genvar gi;
  generate
    for (gi = 0; gi < 4; gi++) begin : g_chain
      cla_adder #(.WIDTH(4)) u_slice (
        .clk(clk), .reset(reset),
        .X(cx[4*gi +: 4]), .Y(cy[4*gi +: 4]), .c0(cc[gi]),
        .S(csum[4*gi +: 4]), .cout(cc[gi+1]), .G(cg[gi]), .P(cp[gi]),
        .ovf(covf[gi]), .S_r(csum_r[4*gi +: 4]), .cout_r(ccout_r[gi]),
        .ovf_r(covf_r[gi])
      );
    end
  endgenerate

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, got timeout, required completion");
    $fatal(1, "watchdog");
  end

  function automatic logic [5:0] model(input logic [3:0] a, input logic [3:0] b, input logic ci);
    logic [4:0] sum;
    int sa, sb, ss;
    sum = {1'b0, a} + {1'b0, b} + {4'b0, ci};
    sa = (a >= 8) ? int'(a) - 16 : int'(a);
    sb = (b >= 8) ? int'(b) - 16 : int'(b);
    ss = sa + sb + int'(ci);
    return {(ss > 7 || ss < -8), sum};
  endfunction

  // Drive at negedge, check combinational outputs, queue registered expectation.
  task automatic apply(input logic [3:0] a, input logic [3:0] b, input logic ci);
    logic [5:0] e;
    @(negedge clk);
    X = a; Y = b; c0 = ci;
    e = model(a, b, ci);
    #1;
    n_vec++;
    if ({cout, S} !== e[4:0]) begin
      n_fail++;
      $display("FAIL sum X=%h Y=%h c0=%b: got %b_%h required %b_%h", a, b, ci, cout, S, e[4], e[3:0]);
    end
    n_vec++;
    if (ovf !== e[5]) begin
      n_fail++;
      $display("FAIL ovf X=%h Y=%h c0=%b: got %b required %b", a, b, ci, ovf, e[5]);
    end
    if (!reset) sb_q.push_back(e);
  endtask

  task automatic check_reg();
    logic [5:0] e;
    @(posedge clk); #1;
    if (sb_q.size() == 0) return;
    e = sb_q.pop_front();
    n_vec++;
    if ({ovf_r, cout_r, S_r} !== e) begin
      n_fail++;
      $display("FAIL reg: got ovf_r=%b cout_r=%b S_r=%h required %b %b %h", ovf_r, cout_r, S_r, e[5], e[4], e[3:0]);
    end
  endtask

  task automatic test_reset();
    #1;
    n_vec++;
    if ({ovf_r, cout_r, S_r} !== 6'b0) begin
      n_fail++;
      $display("FAIL powerup: got %b required 000000", {ovf_r, cout_r, S_r});
    end
    @(negedge clk); reset = 1'b1; X = 4'hF; Y = 4'hF; c0 = 1'b1;
    @(posedge clk); #1;
    n_vec++;
    if ({ovf_r, cout_r, S_r} !== 6'b0) begin
      n_fail++;
      $display("FAIL reset_regs: got %b required 000000", {ovf_r, cout_r, S_r});
    end
    @(negedge clk); reset = 1'b0;
  endtask

  task automatic test_sweep();
    for (int i = 0; i < 512; i++) begin
      logic [3:0] a, b;
      logic ci, eg, ep;
      a = i[3:0]; b = i[7:4]; ci = i[8];
      apply(a, b, ci);
      eg = (({1'b0, a} + {1'b0, b}) > 5'd15);
      ep = ((a ^ b) == 4'hF);
      n_vec++;
      if ({G, P} !== {eg, ep}) begin
        n_fail++;
        $display("FAIL gp X=%h Y=%h: got G=%b P=%b required G=%b P=%b", a, b, G, P, eg, ep);
      end
      n_vec++;
      if (cout !== (G | (P & ci))) begin
        n_fail++;
        $display("FAIL identity X=%h Y=%h c0=%b: got cout=%b required %b", a, b, ci, cout, G | (P & ci));
      end
      check_reg();
    end
  endtask

  task automatic test_corners();
    apply(4'hF, 4'h1, 1'b0);
    n_vec++;
    if ({S, cout, G, P} !== {4'h0, 3'b110}) begin
      n_fail++;
      $display("FAIL corner_f1: got S=%h cout=%b G=%b P=%b required 0 1 1 0", S, cout, G, P);
    end
    check_reg();
    apply(4'hA, 4'h5, 1'b1);
    n_vec++;
    if ({S, cout, G, P} !== {4'h0, 3'b101}) begin
      n_fail++;
      $display("FAIL corner_a5c: got S=%h cout=%b G=%b P=%b required 0 1 0 1", S, cout, G, P);
    end
    check_reg();
    apply(4'hA, 4'h5, 1'b0);
    n_vec++;
    if ({S, cout} !== {4'hF, 1'b0}) begin
      n_fail++;
      $display("FAIL corner_a5: got S=%h cout=%b required F 0", S, cout);
    end
    check_reg();
    apply(4'h7, 4'h1, 1'b0);
    n_vec++;
    if ({S, ovf} !== {4'h8, 1'b1}) begin
      n_fail++;
      $display("FAIL ovf_71: got S=%h ovf=%b required 8 1", S, ovf);
    end
    check_reg();
    apply(4'h8, 4'h8, 1'b0);
    n_vec++;
    if ({S, cout, ovf} !== {4'h0, 2'b11}) begin
      n_fail++;
      $display("FAIL ovf_88: got S=%h cout=%b ovf=%b required 0 1 1", S, cout, ovf);
    end
    check_reg();
    apply(4'hF, 4'h1, 1'b0);
    n_vec++;
    if (ovf !== 1'b0) begin
      n_fail++;
      $display("FAIL ovf_f1: got %b required 0", ovf);
    end
    check_reg();
  endtask

  task automatic test_back_to_back();
    apply(4'h3, 4'h4, 1'b1);
    check_reg();
    n_vec++;
    if ({S_r, cout_r} !== {4'h8, 1'b0}) begin
      n_fail++;
      $display("FAIL latency_n: got S_r=%h cout_r=%b required 8 0", S_r, cout_r);
    end
    apply(4'hF, 4'hF, 1'b1);
    check_reg();
    n_vec++;
    if ({S_r, cout_r} !== {4'hF, 1'b1}) begin
      n_fail++;
      $display("FAIL latency_n1: got S_r=%h cout_r=%b required F 1", S_r, cout_r);
    end
  endtask

  task automatic test_mid_reset();
    // S_r holds F from the previous task; reset clears it while S keeps tracking
    @(negedge clk); reset = 1'b1; X = 4'h2; Y = 4'h5; c0 = 1'b0;
    @(posedge clk); #1;
    n_vec++;
    if ({ovf_r, cout_r, S_r} !== 6'b0) begin
      n_fail++;
      $display("FAIL midreset_regs: got %b required 000000", {ovf_r, cout_r, S_r});
    end
    n_vec++;
    if ({cout, S} !== 5'h07) begin
      n_fail++;
      $display("FAIL midreset_comb: got %b_%h required 0_7", cout, S);
    end
    @(negedge clk); reset = 1'b0;
    sb_q.delete();
    sb_q.push_back(model(4'h2, 4'h5, 1'b0));
    check_reg();
  endtask

  task automatic test_chain();
    logic [16:0] e;
    logic [15:0] av[3] = '{16'hFFFF, 16'h1234, 16'h8000};
    logic [15:0] bv[3] = '{16'h0001, 16'h4321, 16'h8000};
    for (int i = 0; i < 3; i++) begin
      @(negedge clk); cx = av[i]; cy = bv[i];
      e = {1'b0, av[i]} + {1'b0, bv[i]};
      #1;
      n_vec++;
      if ({cc[4], csum} !== e) begin
        n_fail++;
        $display("FAIL chain %h+%h: got %b_%h required %b_%h", av[i], bv[i], cc[4], csum, e[16], e[15:0]);
      end
      @(posedge clk); #1;
      n_vec++;
      if ({ccout_r[3], csum_r} !== e) begin
        n_fail++;
        $display("FAIL chain_reg %h+%h: got %b_%h required %b_%h", av[i], bv[i], ccout_r[3], csum_r, e[16], e[15:0]);
      end
    end
  endtask

  initial begin
    test_reset();
    test_sweep();
    test_corners();
    test_back_to_back();
    test_mid_reset();
    test_chain();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule
